// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding an 8-bit UART transmitter (8N1, or 8E1 when SERIAL_TX_PARITY_EN is defined).
// Frames are sent back-to-back while the FIFO holds data; OUT_OVERFLOW records any dropped push.
module serial_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IN_DATA,
  input  logic       IN_SEND,
  output logic       OUT_SERIAL_TX,
  output logic       OUT_READY,
  output logic       OUT_BUSY,
  output logic       OUT_OVERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0]       BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] FULL      = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  ovf_q, ovf_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            mem_q [DEPTH];
`ifdef SERIAL_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic push;
  logic pop;
  logic baud_done;
  logic fifo_ne;
  logic [7:0] head;

  assign push      = IN_SEND & ready_q & RESET;
  assign baud_done = (baud_q == BAUD_LAST);
  assign fifo_ne   = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  // Frame sequencer; pops happen only from IDLE or at the final edge of STOP.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (fifo_ne) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^head;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (fifo_ne) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef SERIAL_TX_PARITY_EN
            parity_d = ^head;
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // The line is driven from the current state, so it trails the state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL);
    ovf_d   = ovf_q | (IN_SEND & ~ready_q);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Storage has no reset; pointers and count define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= IN_DATA;
  end

  assign OUT_SERIAL_TX = tx_q;
  assign OUT_READY     = ready_q;
  assign OUT_OVERFLOW  = ovf_q;
  assign OUT_BUSY      = (state_q != S_IDLE) || (count_q != '0);

endmodule
